// File: rtl/corectrl_pkg.sv
// corectrl: shared decode types, opcode constants and the queue entry layout.
package corectrl;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_AMO    = 7'b0101111;

    typedef enum logic [2:0] {INST_X, INST_R, INST_I, INST_S, INST_B, INST_U, INST_J} InstType;

    typedef enum logic [3:0] {EXC_NONE = 4'd0, ILLEGAL_INSTRUCTION = 4'd2} ExcCause;

    typedef struct packed {
        InstType    itype;
        logic       rwb_en;
        logic       aluop;
        logic       muldiv;
        logic       is_load;
        logic       jump;
        logic       is_lui;
        logic       is_op32;
        logic       is_csr;
        logic       is_amo;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } InstCtrl;

    // value/addr/imm are held at the widest XLEN and truncated at the ports
    typedef struct packed {
        logic        valid;
        ExcCause     cause;
        logic [63:0] value;
    } ExceptionInfo;

    typedef struct packed {
        logic [63:0]  addr;
        logic [31:0]  bits;
        InstCtrl      ctrl;
        logic [63:0]  imm;
        ExceptionInfo expt;
    } DecodedInst;

endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: combinational RV32/RV64 decode of one word into ctrl/imm/expt.
// AMO opcodes are decoded only when DECODE_AMO_EN is defined.
module inst_decoder
    import corectrl::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     bits,
    output InstCtrl         ctrl,
    output logic [XLEN-1:0] imm,
    output ExceptionInfo    expt
);

    logic [6:0]  op;
    logic        illegal;
    logic [63:0] imm64;

    always_comb begin
        op = bits[6:0];
        ctrl = '0;
        ctrl.funct3 = bits[14:12];
        ctrl.funct7 = bits[31:25];
        illegal = 1'b0;
        case (op)
            OP_OP, OP_OP32: begin
                ctrl.itype = INST_R;
                ctrl.aluop = 1'b1;
                ctrl.muldiv = bits[31:25] == 7'b0000001;
                ctrl.is_op32 = op == OP_OP32;
                illegal = op == OP_OP32 && XLEN == 32;
            end
            OP_IMM, OP_IMM32: begin
                ctrl.itype = INST_I;
                ctrl.aluop = 1'b1;
                ctrl.is_op32 = op == OP_IMM32;
                illegal = op == OP_IMM32 && XLEN == 32;
            end
            OP_LOAD: begin
                ctrl.itype = INST_I;
                ctrl.is_load = 1'b1;
            end
            OP_STORE:  ctrl.itype = INST_S;
            OP_BRANCH: ctrl.itype = INST_B;
            OP_JAL: begin
                ctrl.itype = INST_J;
                ctrl.jump = 1'b1;
            end
            OP_JALR: begin
                ctrl.itype = INST_I;
                ctrl.jump = 1'b1;
            end
            OP_LUI: begin
                ctrl.itype = INST_U;
                ctrl.is_lui = 1'b1;
            end
            OP_AUIPC:  ctrl.itype = INST_U;
            OP_SYSTEM: begin
                ctrl.itype = INST_I;
                ctrl.is_csr = 1'b1;
            end
`ifdef DECODE_AMO_EN
            OP_AMO: begin
                ctrl.itype = INST_R;
                ctrl.is_amo = 1'b1;
                illegal = !(bits[14:12] == 3'b010 || (bits[14:12] == 3'b011 && XLEN == 64));
            end
`endif
            default: illegal = 1'b1;
        endcase
        illegal = illegal || bits[1:0] != 2'b11;
        if (illegal) begin
            ctrl = '0;
            ctrl.funct3 = bits[14:12];
            ctrl.funct7 = bits[31:25];
        end
        ctrl.rwb_en = ctrl.itype inside {INST_R, INST_I, INST_U, INST_J};
        imm64 = ctrl.itype == INST_I ? {{52{bits[31]}}, bits[31:20]} :
                ctrl.itype == INST_S ? {{52{bits[31]}}, bits[31:25], bits[11:7]} :
                ctrl.itype == INST_B ? {{51{bits[31]}}, bits[31], bits[7], bits[30:25], bits[11:8], 1'b0} :
                ctrl.itype == INST_U ? {{32{bits[31]}}, bits[31:12], 12'b0} :
                ctrl.itype == INST_J ? {{43{bits[31]}}, bits[31], bits[19:12], bits[20], bits[30:21], 1'b0} :
                64'b0;
        imm = imm64[XLEN-1:0];
        expt.valid = illegal;
        expt.cause = illegal ? ILLEGAL_INSTRUCTION : EXC_NONE;
        expt.value = illegal ? {32'b0, bits} : 64'b0;
    end

endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: decode at enqueue, then a DEPTH-entry in-order valid/ready queue.
// AMO decode is enabled by defining DECODE_AMO_EN.
module inst_decode_queue
    import corectrl::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_addr,
    input  logic [31:0]              in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_addr,
    output logic [31:0]              out_bits,
    output InstCtrl                  out_ctrl,
    output logic [XLEN-1:0]          out_imm,
    output ExceptionInfo             out_expt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    InstCtrl         dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    ExceptionInfo    dec_expt;
    DecodedInst      mem_q [DEPTH];
    DecodedInst      wr_entry;
    DecodedInst      head;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    inst_decoder #(.XLEN(XLEN)) u_dec (
        .bits (in_bits),
        .ctrl (dec_ctrl),
        .imm  (dec_imm),
        .expt (dec_expt)
    );

    always_comb begin
        out_valid = count_q != '0;
        pop = out_valid && out_ready;
        in_ready = !flush && (count_q < CW'(DEPTH) || pop);
        push = in_valid && in_ready;
        wr_d = flush ? '0 : wr_q + PW'(push);
        rd_d = flush ? '0 : rd_q + PW'(pop);
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        wr_entry = '{addr: 64'(in_addr), bits: in_bits, ctrl: dec_ctrl, imm: 64'(dec_imm), expt: dec_expt};
        head = mem_q[rd_q];
        out_addr = head.addr[XLEN-1:0];
        out_bits = head.bits;
        out_ctrl = head.ctrl;
        out_imm = head.imm[XLEN-1:0];
        out_expt = head.expt;
        count = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end

    // payload storage needs no reset: out_valid masks stale entries
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= wr_entry;
    end

endmodule

// File: tb/tb_inst_decode_queue.sv
// tb_inst_decode_queue: directed steps with a scoreboard of expected decoded entries.
module tb_inst_decode_queue;
    import corectrl::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] bits;
        InstType     itype;
        logic        rwb;
        logic [7:0]  flags;
        logic [63:0] imm;
        logic        ev;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0]  in_addr, out_addr, out_imm;
    logic [31:0]  in_bits, out_bits;
    InstCtrl      out_ctrl;
    ExceptionInfo out_expt;
    logic [2:0]   count;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    inst_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_bits(out_bits),
        .out_ctrl(out_ctrl), .out_imm(out_imm), .out_expt(out_expt), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] a, input logic [31:0] b, input InstType t,
                                input logic rwb, input logic [7:0] f, input logic [63:0] imm, input logic ev);
        exp_t e;
        e.addr = a; e.bits = b; e.itype = t; e.rwb = rwb; e.flags = f; e.imm = imm; e.ev = ev;
        return e;
    endfunction

    // flags = {aluop, muldiv, is_load, jump, is_lui, is_op32, is_csr, is_amo}
    task automatic cyc(input logic v, input exp_t e, input logic ordy, input logic fl);
        logic exp_v, exp_rdy;
        exp_t h;
        in_valid = v; in_addr = e.addr; in_bits = e.bits; out_ready = ordy; flush = fl;
        #1;
        exp_v = sb.size() != 0;
        exp_rdy = !fl && (sb.size() < DEPTH || (exp_v && ordy));
        chk("out_valid", 64'(out_valid), 64'(exp_v));
        chk("count", 64'(count), 64'(sb.size()));
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (exp_v && ordy) begin
            h = sb.pop_front();
            chk("addr", out_addr, h.addr);
            chk("bits", 64'(out_bits), 64'(h.bits));
            chk("itype", 64'(out_ctrl.itype), 64'(h.itype));
            chk("rwb_en", 64'(out_ctrl.rwb_en), 64'(h.rwb));
            chk("flags", 64'({out_ctrl.aluop, out_ctrl.muldiv, out_ctrl.is_load, out_ctrl.jump,
                              out_ctrl.is_lui, out_ctrl.is_op32, out_ctrl.is_csr, out_ctrl.is_amo}), 64'(h.flags));
            chk("funct3", 64'(out_ctrl.funct3), 64'(h.bits[14:12]));
            chk("expt_valid", 64'(out_expt.valid), 64'(h.ev));
            if (h.ev) begin
                chk("expt_cause", 64'(out_expt.cause), 64'(ILLEGAL_INSTRUCTION));
                chk("expt_value", out_expt.value, {32'b0, h.bits});
            end else begin
                chk("imm", out_imm, h.imm);
            end
        end
        if (fl) sb.delete();
        else if (v && exp_rdy) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    exp_t nop, addi, lw, sw, beq, jal, luin, lui, ill, auipc, jalr, addw, mul, csr, amo;

    initial begin
        nop   = mk(64'h0,    32'h00000013, INST_I, 1'b0, 8'h00, 64'h0, 1'b0);
        addi  = mk(64'h1000, 32'h00500093, INST_I, 1'b1, 8'h80, 64'd5, 1'b0);
        lw    = mk(64'h1004, 32'hFFC0A103, INST_I, 1'b1, 8'h20, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        sw    = mk(64'h1008, 32'h0020A423, INST_S, 1'b0, 8'h00, 64'd8, 1'b0);
        beq   = mk(64'h100C, 32'hFE208CE3, INST_B, 1'b0, 8'h00, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        jal   = mk(64'h1010, 32'h010000EF, INST_J, 1'b1, 8'h10, 64'd16, 1'b0);
        luin  = mk(64'h1014, 32'h800002B7, INST_U, 1'b1, 8'h08, 64'hFFFFFFFF80000000, 1'b0);
        lui   = mk(64'h2000, 32'h123452B7, INST_U, 1'b1, 8'h08, 64'h12345000, 1'b0);
        ill   = mk(64'h2004, 32'hFFFFFFFF, INST_X, 1'b0, 8'h00, 64'h0, 1'b1);
        auipc = mk(64'h2008, 32'hFFFFF197, INST_U, 1'b1, 8'h00, 64'hFFFFFFFFFFFFF000, 1'b0);
        jalr  = mk(64'h200C, 32'h000100E7, INST_I, 1'b1, 8'h10, 64'h0, 1'b0);
        addw  = mk(64'h3000, 32'h001080BB, INST_R, 1'b1, 8'h84, 64'h0, 1'b0);
        mul   = mk(64'h3004, 32'h021080B3, INST_R, 1'b1, 8'hC0, 64'h0, 1'b0);
        csr   = mk(64'h3008, 32'h300110F3, INST_I, 1'b1, 8'h02, 64'h300, 1'b0);
`ifdef DECODE_AMO_EN
        amo   = mk(64'h300C, 32'h0020A1AF, INST_R, 1'b1, 8'h01, 64'h0, 1'b0);
`else
        amo   = mk(64'h300C, 32'h0020A1AF, INST_X, 1'b0, 8'h00, 64'h0, 1'b1);
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_addr = 64'h1000; in_bits = 32'h00500093; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        cyc(1'b1, addi, 1'b0, 1'b0);
        cyc(1'b0, nop, 1'b1, 1'b0);
        cyc(1'b1, lw, 1'b0, 1'b0);
        cyc(1'b1, sw, 1'b0, 1'b0);
        cyc(1'b1, beq, 1'b0, 1'b0);
        cyc(1'b1, jal, 1'b0, 1'b0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, luin, 1'b0, 1'b0);
        cyc(1'b1, luin, 1'b1, 1'b0);
        chk("full_push_pop_count", 64'(count), 64'(DEPTH));
        repeat (5) cyc(1'b0, nop, 1'b1, 1'b0);
        cyc(1'b1, ill, 1'b1, 1'b0);
        cyc(1'b1, lui, 1'b1, 1'b0);
        cyc(1'b1, auipc, 1'b1, 1'b0);
        cyc(1'b1, jalr, 1'b1, 1'b0);
        cyc(1'b0, nop, 1'b1, 1'b0);
        cyc(1'b1, addi, 1'b0, 1'b0);
        cyc(1'b1, lw, 1'b0, 1'b0);
        cyc(1'b1, sw, 1'b0, 1'b0);
        cyc(1'b1, csr, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        cyc(1'b0, nop, 1'b1, 1'b0);
        cyc(1'b1, addw, 1'b0, 1'b0);
        cyc(1'b1, mul, 1'b0, 1'b0);
        cyc(1'b1, csr, 1'b0, 1'b0);
        cyc(1'b1, amo, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, nop, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
